ahbl_apb3_bridge: RTL
=====================

Name: ahbl_apb3_bridge

Overview:
AHB-Lite slave to APB3 master bridge. It sits directly downstream of the AHB-Lite master/BFM stage and converts each AHB-Lite transfer into one APB3 transfer toward CoreUARTapb and other APB peripherals. It decodes a one-hot PSEL from the upper address bits and holds the AHB data phase with wait states until the APB access completes.

Parameters:
ADDR_WIDTH, 16, width of PADDR (taken from HADDR[ADDR_WIDTH-1:0])
SEL_BITS, 4, HADDR bits above PADDR used to decode PSEL; PSEL width = 2**SEL_BITS

Ports:
HCLK  in  1  single clock for AHB and APB sides
HRESETN  in  1  asynchronous active-low reset
HSEL  in  1  bridge selected by the AHB decoder
HADDR  in  32  AHB address
HTRANS  in  2  AHB transfer type
HWRITE  in  1  AHB write when 1
HSIZE  in  3  AHB size; accepted but not forwarded
HWDATA  in  32  AHB write data
HREADYIN  in  1  bus-wide HREADY
HREADYOUT  out  1  bridge ready
HRDATA  out  32  read data
HRESP  out  1  0=OKAY, 1=ERROR
PADDR  out  ADDR_WIDTH  APB address
PSEL  out  2**SEL_BITS  one-hot APB select
PENABLE  out  1  APB access phase
PWRITE  out  1  APB direction
PWDATA  out  32  APB write data
PRDATA  in  32  muxed APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- Reset values (asynchronous, effective immediately): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, PADDR=0, PSEL=0, PENABLE=0, PWRITE=0, PWDATA=0.
- Valid transfer: HSEL & HREADYIN & HTRANS[1] (NONSEQ or SEQ). The bridge samples it only in IDLE, DONE or ERR2. On a valid transfer it latches HADDR and HWRITE.
- HTRANS IDLE or BUSY with HSEL=1: no APB activity. The bridge gives a zero-wait OKAY response.
- State IDLE: HREADYOUT=1. On a valid transfer, go to SETUP.
- State SETUP (1 cycle):
  - PSEL[HADDR[ADDR_WIDTH+SEL_BITS-1:ADDR_WIDTH]]=1, PENABLE=0, HREADYOUT=0.
  - PWDATA is passed through from HWDATA and captured into a register at the end of SETUP.
  - Next state is ACCESS.
- State ACCESS:
  - PENABLE=1. PSEL, PADDR, PWRITE and PWDATA (now the register) are held stable. HREADYOUT=0.
  - While PREADY=0, stay in ACCESS (no timeout).
  - On PREADY=1 with PSLVERR=0: register PRDATA into HRDATA on reads, then go to DONE.
  - On PREADY=1 with PSLVERR=1: go to ERR1 (see Optional Feature).
- State DONE (1 cycle):
  - PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=0.
  - A valid transfer goes to SETUP; otherwise go to IDLE.
- State ERR1: HREADYOUT=0, HRESP=1, APB idle. Next state is ERR2.
- State ERR2: HREADYOUT=1, HRESP=1. A valid transfer goes to SETUP; otherwise go to IDLE.
- Latency: a zero-wait APB access costs 2 AHB wait states, with the data phase completing 3 cycles after the address phase. Each PREADY=0 cycle adds one wait state.
- HRDATA holds its last read value; it is not updated on writes or errors.
- Sizes: byte and halfword transfers issue a full 32-bit APB access with unaltered lanes. PADDR carries the untruncated low address bits.
- Reset asserted mid-ACCESS: PSEL and PENABLE drop immediately and the APB transfer is abandoned.

Optional Feature:
- Macro: AHBL_APB3_PSLVERR_EN.
- Defined: PSLVERR=1 at PREADY=1 produces the two-cycle ERROR response (ERR1 then ERR2).
- Undefined: PSLVERR is ignored. The transfer goes to DONE with OKAY, read data is still captured, and the ERR1/ERR2 states are not compiled.

Decomposition:
- Shared package holds:
  - state enum (IDLE, SETUP, ACCESS, DONE, ERR1, ERR2)
  - HTRANS constants (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11)
  - HRESP constants (OKAY=0, ERROR=1)
- One sub-module: ahbl_apb3_psel_dec, a combinational one-hot decoder driven by the latched select bits and gated by the SETUP/ACCESS state.

Test Plan:
- Write 0x0000_00A5 to HADDR 0x0001_0004, PREADY tied 1 -> PSEL[1]=1, PADDR=0x0004, PWDATA=0xA5 stable in SETUP and ACCESS, HREADYOUT low for 2 cycles, HRESP=0.
- Read HADDR 0x0002_0010, PREADY low for 3 ACCESS cycles, PRDATA=0xDEADBEEF -> PSEL[2], 5 wait states, HRDATA=0xDEADBEEF when HREADYOUT=1.
- Back-to-back NONSEQ write then read presented in the DONE cycle -> SETUP entered immediately, no IDLE cycle, and PSEL is 0 for exactly 1 cycle between the accesses.
- PSLVERR=1 with PREADY=1 on a write -> with the macro: HRESP=1 for 2 cycles, HREADYOUT 0 then 1. Without the macro: OKAY response.
- HSEL=1 with HTRANS=BUSY, then IDLE -> HREADYOUT stays 1, HRESP=0, PSEL stays 0.
- HRESETN pulsed low while in ACCESS with PREADY=0 -> PSEL=0, PENABLE=0 and HREADYOUT=1 asynchronously. After release, a new transfer completes normally.

Source files
------------

// File: rtl/ahbl_apb3_bridge_pkg.sv
// Shared types and constants for the AHB-Lite to APB3 bridge.
// Holds the bridge FSM encoding and the AHB HTRANS/HRESP codes.
package ahbl_apb3_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // NONSEQ and SEQ carry data; IDLE and BUSY never start an APB access
    function automatic logic htrans_active(input logic [1:0] t);
        return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahbl_apb3_psel_dec.sv
// One-hot APB select decoder for the AHB-Lite to APB3 bridge.
// Drives a single PSEL bit from the latched select field while enabled.
module ahbl_apb3_psel_dec #(
    parameter int SEL_BITS = 4
) (
    input  logic [SEL_BITS-1:0]     sel,
    input  logic                    en,
    output logic [2**SEL_BITS-1:0]  psel
);

    // Only the addressed peripheral is selected, and only during SETUP/ACCESS
    always_comb begin
        psel = '0;
        if (en) begin
            psel[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/ahbl_apb3_bridge.sv
// AHB-Lite slave to APB3 master bridge, one APB transfer per AHB transfer.
// Define AHBL_APB3_PSLVERR_EN to turn PSLVERR into a two-cycle AHB ERROR.
module ahbl_apb3_bridge
    import ahbl_apb3_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int SEL_BITS   = 4
) (
    input  logic                    HCLK,
    input  logic                    HRESETN,
    input  logic                    HSEL,
    input  logic [31:0]             HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [31:0]             HWDATA,
    input  logic                    HREADYIN,
    output logic                    HREADYOUT,
    output logic [31:0]             HRDATA,
    output logic                    HRESP,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [2**SEL_BITS-1:0]  PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [31:0]             PWDATA,
    input  logic [31:0]             PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    state_t                 state;
    state_t                 state_nx;
    logic [ADDR_WIDTH-1:0]  paddr_q;
    logic [SEL_BITS-1:0]    sel_q;
    logic                   pwrite_q;
    logic [31:0]            pwdata_q;
    logic [31:0]            hrdata_q;
    logic                   valid;
    logic                   accept;
    logic                   rd_capture;
    logic                   apb_on;
    logic                   unused;

    // Lanes are not narrowed, so HSIZE and the address bits above
    // the select field have no effect on the APB side.
`ifdef AHBL_APB3_PSLVERR_EN
    assign unused = ^{HSIZE, HADDR[31:ADDR_WIDTH+SEL_BITS]};
`else
    assign unused = ^{HSIZE, HADDR[31:ADDR_WIDTH+SEL_BITS], PSLVERR};
`endif

    assign valid  = HSEL & HREADYIN & htrans_active(HTRANS);
    assign accept = valid & ((state == ST_IDLE) |
                             (state == ST_DONE) |
                             (state == ST_ERR2));
    assign apb_on = (state == ST_SETUP) | (state == ST_ACCESS);

`ifdef AHBL_APB3_PSLVERR_EN
    assign rd_capture = (state == ST_ACCESS) & PREADY & ~PSLVERR & ~pwrite_q;
`else
    assign rd_capture = (state == ST_ACCESS) & PREADY & ~pwrite_q;
`endif

    // State register plus the address/data/read-back holding registers
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state    <= ST_IDLE;
            paddr_q  <= '0;
            sel_q    <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            hrdata_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                paddr_q  <= HADDR[ADDR_WIDTH-1:0];
                sel_q    <= HADDR[ADDR_WIDTH+SEL_BITS-1:ADDR_WIDTH];
                pwrite_q <= HWRITE;
            end
            if (state == ST_SETUP) begin
                pwdata_q <= HWDATA;
            end
            if (rd_capture) begin
                hrdata_q <= PRDATA;
            end
        end
    end

    // Next-state and AHB response decode
    always_comb begin
        state_nx  = state;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        case (state)
            ST_IDLE: begin
                if (valid) state_nx = ST_SETUP;
            end
            ST_SETUP: begin
                HREADYOUT = 1'b0;
                state_nx  = ST_ACCESS;
            end
            ST_ACCESS: begin
                HREADYOUT = 1'b0;
                if (PREADY) begin
`ifdef AHBL_APB3_PSLVERR_EN
                    state_nx = PSLVERR ? ST_ERR1 : ST_DONE;
`else
                    state_nx = ST_DONE;
`endif
                end
            end
            ST_DONE: begin
                state_nx = valid ? ST_SETUP : ST_IDLE;
            end
`ifdef AHBL_APB3_PSLVERR_EN
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_nx  = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP    = HRESP_ERROR;
                state_nx = valid ? ST_SETUP : ST_IDLE;
            end
`endif
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign PADDR   = paddr_q;
    assign PWRITE  = pwrite_q;
    assign PENABLE = (state == ST_ACCESS);
    assign PWDATA  = (state == ST_SETUP) ? HWDATA : pwdata_q;
    assign HRDATA  = hrdata_q;

    ahbl_apb3_psel_dec #(
        .SEL_BITS (SEL_BITS)
    ) u_psel_dec (
        .sel  (sel_q),
        .en   (apb_on),
        .psel (PSEL)
    );

endmodule
